oled_spi_receiver: RTL and testbench

Receive-side counterpart of the cycle computer's OLED display link (nCS, DnC, SCLK, SDIN). It oversamples the four serial lines in the Clock domain, deserialises MSB-first bytes, and tags each byte as command or data. Bytes are buffered in a small FWFT FIFO behind a valid/ready handshake. Used as the display-side endpoint in chip-level benches and as a synthesizable capture block for the display driver.

---
 rtl/oled_spi_receiver.sv | 176 +++++++++++++++++
 tb/tb_oled_spi_receiver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/oled_spi_receiver.sv
// Display-side endpoint for the OLED serial link (nCS, DnC, SCLK, SDIN).
// Synchronises the four serial lines into the Clock domain and deserialises
// MSB-first bytes tagged as command or data.
// Received bytes sit in a small first-word-fall-through FIFO behind a
// valid/ready handshake.
module oled_spi_receiver #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        nCS,
   input  logic        SCLK,
   input  logic        SDIN,
   input  logic        DnC,
   output logic [7:0]  RxData,
   output logic        RxIsData,
   output logic        RxValid,
   input  logic        RxReady,
   output logic        FrameError,
   output logic        Overflow,
   output logic [15:0] ByteCount
);

   localparam int PtrW = $clog2(FIFO_DEPTH);
   localparam int CntW = PtrW + 1;

   // Bit order inside a sync word: {nCS, SCLK, SDIN, DnC}; idle is nCS high, rest low.
   localparam logic [3:0] SyncIdle = 4'b1000;

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [3:0]      syncReg [SYNC_STAGES];
   logic [3:0]      pinsNow;
   logic            ncsSync, sclkSync, sdinSync, dncSync;
   logic            ncsPrevReg, sclkPrevReg;
   logic            ncsRise, sclkRise;
   state_t          stateReg, stateNext;
   logic            shiftEn, frameErrNext;
   logic [2:0]      bitCntReg;
   logic [7:0]      shiftReg;
   logic            push, pop, pushOk, fifoFull;
   logic [7:0]      pushByte;
   logic [8:0]      fifoMem [FIFO_DEPTH];
   logic [PtrW-1:0] wrPtrReg, rdPtrReg;
   logic [CntW-1:0] countReg;
   logic [8:0]      headWord;
   logic            frameErrReg, overflowReg;
   logic [15:0]     byteCountReg;

   assign pinsNow = {nCS, SCLK, SDIN, DnC};

   // First synchroniser stage captures the raw pins.
   always_ff @(posedge Clock) begin
      if (Reset) syncReg[0] <= SyncIdle;
      else       syncReg[0] <= pinsNow;
   end

   genvar gi;
   generate
      for (gi = 1; gi < SYNC_STAGES; gi++) begin : gSync
         // Remaining synchroniser stages, all reset to the idle line levels.
         always_ff @(posedge Clock) begin
            if (Reset) syncReg[gi] <= SyncIdle;
            else       syncReg[gi] <= syncReg[gi-1];
         end
      end
   endgenerate

   assign {ncsSync, sclkSync, sdinSync, dncSync} = syncReg[SYNC_STAGES-1];

   // Delayed copies of synced nCS and SCLK for edge detection.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ncsPrevReg  <= 1'b1;
         sclkPrevReg <= 1'b0;
      end else begin
         ncsPrevReg  <= ncsSync;
         sclkPrevReg <= sclkSync;
      end
   end

   assign ncsRise  = ncsSync & ~ncsPrevReg;
   assign sclkRise = sclkSync & ~sclkPrevReg;

   // Frame state register.
   always_ff @(posedge Clock) begin
      if (Reset) stateReg <= IDLE;
      else       stateReg <= stateNext;
   end

   // Next state and shift strobe; a deselect wins over a coincident SCLK edge.
   always_comb begin
      stateNext    = stateReg;
      shiftEn      = 1'b0;
      frameErrNext = 1'b0;
      case (stateReg)
         IDLE: begin
            if (!ncsSync) stateNext = SHIFT;
         end
         SHIFT: begin
            if (ncsSync) begin
               stateNext    = IDLE;
               frameErrNext = ncsRise && (bitCntReg != 3'd0);
            end else if (sclkRise) begin
               shiftEn = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Bit counter and shift register; the counter is held at zero outside a frame.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         bitCntReg <= 3'd0;
         shiftReg  <= 8'd0;
      end else begin
         if (stateReg != SHIFT || ncsSync) bitCntReg <= 3'd0;
         else if (shiftEn)                 bitCntReg <= bitCntReg + 3'd1;
         if (shiftEn) shiftReg <= {shiftReg[6:0], sdinSync};
      end
   end

   // The eighth edge completes a byte and pushes it in the same cycle.
   assign push     = shiftEn && (bitCntReg == 3'd7);
   assign pushByte = {shiftReg[6:0], sdinSync};
   assign fifoFull = (countReg == CntW'(FIFO_DEPTH));
   assign pop      = RxValid && RxReady;
   assign pushOk   = push && (!fifoFull || pop);

   // FIFO storage; written only on accepted pushes.
   always_ff @(posedge Clock) begin
      if (pushOk) fifoMem[wrPtrReg] <= {dncSync, pushByte};
   end

   // FIFO pointers and occupancy; pointers wrap because the depth is a power of two.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
         countReg <= '0;
      end else begin
         if (pushOk) wrPtrReg <= wrPtrReg + 1'b1;
         if (pop)    rdPtrReg <= rdPtrReg + 1'b1;
         case ({pushOk, pop})
            2'b10:   countReg <= countReg + 1'b1;
            2'b01:   countReg <= countReg - 1'b1;
            default: countReg <= countReg;
         endcase
      end
   end

   // Status: one-cycle frame error pulse, sticky overflow, accepted byte count.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         frameErrReg  <= 1'b0;
         overflowReg  <= 1'b0;
         byteCountReg <= 16'd0;
      end else begin
         frameErrReg <= frameErrNext;
         if (push && fifoFull && !pop) overflowReg <= 1'b1;
         if (pushOk) byteCountReg <= byteCountReg + 16'd1;
      end
   end

   // Head of FIFO is shown directly; forced to zero while empty.
   assign headWord   = fifoMem[rdPtrReg];
   assign RxValid    = (countReg != '0);
   assign RxData     = RxValid ? headWord[7:0] : 8'd0;
   assign RxIsData   = RxValid ? headWord[8] : 1'b0;
   assign FrameError = frameErrReg;
   assign Overflow   = overflowReg;
   assign ByteCount  = byteCountReg;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: reset, command/data bytes, burst,
// overflow, frame error and full-FIFO simultaneous push/pop.
module tb_oled_spi_receiver;

   localparam int SS = 2;

   logic        Clock = 1'b0;
   logic        Reset, nCS, SCLK, SDIN, DnC, RxReady;
   logic [7:0]  RxData;
   logic        RxIsData, RxValid, FrameError, Overflow;
   logic [15:0] ByteCount;

   int totalCnt = 0;
   int badCnt   = 0;
   int errCycles = 0;
   logic [8:0] gotQ [$];

   oled_spi_receiver #(.FIFO_DEPTH(4), .SYNC_STAGES(SS)) dut (
      .Clock(Clock), .Reset(Reset), .nCS(nCS), .SCLK(SCLK), .SDIN(SDIN), .DnC(DnC),
      .RxData(RxData), .RxIsData(RxIsData), .RxValid(RxValid), .RxReady(RxReady),
      .FrameError(FrameError), .Overflow(Overflow), .ByteCount(ByteCount)
   );

   always #5 Clock = ~Clock;

   // Record every pop and every cycle with FrameError high, just after the falling edge.
   always @(negedge Clock) begin
      #1;
      if (RxValid && RxReady) gotQ.push_back({RxIsData, RxData});
      if (FrameError) errCycles++;
   end

   task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
      totalCnt++;
      if (got !== exp) begin
         badCnt++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic waitNeg(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic applyReset();
      Reset = 1'b1; nCS = 1'b1; SCLK = 1'b0; SDIN = 1'b0; DnC = 1'b0; RxReady = 1'b0;
      waitNeg(3);
      Reset = 1'b0;
      waitNeg(2);
      gotQ.delete();
      errCycles = 0;
   endtask

   // mode 0: plain; 1: check latency on last bit; 2: pulse RxReady in the push cycle.
   task automatic sendBits(input logic [7:0] b, input logic d, input int nBits, input int mode);
      for (int i = 7; i > 7 - nBits; i--) begin
         SDIN = b[i];
         DnC  = d;
         waitNeg(4);
         SCLK = 1'b1;
         if (i == 0 && mode == 1) begin
            waitNeg(SS);
            checkVal("lat_early", 16'(RxValid), 16'd0);
            waitNeg(2);
            checkVal("lat_valid", 16'(RxValid), 16'd1);
         end else if (i == 0 && mode == 2) begin
            waitNeg(SS);
            RxReady = 1'b1;
            waitNeg(1);
            RxReady = 1'b0;
            waitNeg(4 - SS - 1);
         end else begin
            waitNeg(4);
         end
         SCLK = 1'b0;
      end
      $display("tx bits=%0d byte=%h dnc=%b", nBits, b, d);
   endtask

   task automatic drain();
      RxReady = 1'b1;
      waitNeg(10);
      RxReady = 1'b0;
      waitNeg(2);
   endtask

   task automatic checkQueue(input string tag, input logic [8:0] exp [$]);
      checkVal({tag, "_n"}, 16'(gotQ.size()), 16'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         if (i < gotQ.size()) checkVal(tag, 16'(gotQ[i]), 16'(exp[i]));
         else                 checkVal(tag, 16'h1ff, 16'(exp[i]));
      end
   endtask

   initial begin
      logic [8:0] expQ [$];

      // Reset / idle
      applyReset();
      checkVal("rst_valid", 16'(RxValid), 16'd0);
      checkVal("rst_data", 16'(RxData), 16'd0);
      checkVal("rst_isdata", 16'(RxIsData), 16'd0);
      checkVal("rst_ferr", 16'(FrameError), 16'd0);
      checkVal("rst_ovf", 16'(Overflow), 16'd0);
      checkVal("rst_cnt", ByteCount, 16'd0);

      // Single command byte with latency check
      nCS = 1'b0; waitNeg(4);
      sendBits(8'hAF, 1'b0, 8, 1);
      checkVal("cmd_data", 16'(RxData), 16'h00AF);
      checkVal("cmd_isdata", 16'(RxIsData), 16'd0);
      checkVal("cmd_cnt", ByteCount, 16'd1);
      RxReady = 1'b1; waitNeg(1); RxReady = 1'b0; waitNeg(1);
      checkVal("cmd_popped", 16'(RxValid), 16'd0);
      waitNeg(4); nCS = 1'b1; waitNeg(8);
      checkVal("cmd_noferr", 16'(errCycles), 16'd0);

      // Burst of data bytes in one frame with consumer always ready
      applyReset();
      RxReady = 1'b1; nCS = 1'b0; waitNeg(4);
      sendBits(8'h01, 1'b1, 8, 0);
      sendBits(8'h80, 1'b1, 8, 0);
      sendBits(8'hFF, 1'b1, 8, 0);
      sendBits(8'h5A, 1'b1, 8, 0);
      waitNeg(6); nCS = 1'b1; waitNeg(8); RxReady = 1'b0;
      expQ = '{9'h101, 9'h180, 9'h1FF, 9'h15A};
      checkQueue("burst", expQ);
      checkVal("burst_cnt", ByteCount, 16'd4);
      checkVal("burst_noferr", 16'(errCycles), 16'd0);

      // Overflow: six bytes into a four-deep FIFO
      applyReset();
      nCS = 1'b0; waitNeg(4);
      for (int k = 0; k < 6; k++) begin
         sendBits(8'h10 + 8'(k), 1'b0, 8, 0);
         if (k == 3) checkVal("ovf_before", 16'(Overflow), 16'd0);
         if (k == 4) checkVal("ovf_set", 16'(Overflow), 16'd1);
      end
      checkVal("ovf_cnt", ByteCount, 16'd4);
      checkVal("ovf_head", 16'(RxData), 16'h0010);
      waitNeg(4); nCS = 1'b1; waitNeg(8);
      drain();
      expQ = '{9'h010, 9'h011, 9'h012, 9'h013};
      checkQueue("ovf_drain", expQ);
      checkVal("ovf_sticky", 16'(Overflow), 16'd1);
      checkVal("ovf_empty", 16'(RxValid), 16'd0);

      // Frame error: five bits then deselect
      applyReset();
      nCS = 1'b0; waitNeg(4);
      sendBits(8'hC3, 1'b0, 5, 0);
      waitNeg(4); nCS = 1'b1; waitNeg(10);
      checkVal("ferr_pulse", 16'(errCycles), 16'd1);
      checkVal("ferr_nopush", 16'(RxValid), 16'd0);
      checkVal("ferr_cnt", ByteCount, 16'd0);
      nCS = 1'b0; waitNeg(4);
      sendBits(8'h3C, 1'b1, 8, 0);
      checkVal("ferr_next", 16'(RxData), 16'h003C);
      checkVal("ferr_next_tag", 16'(RxIsData), 16'd1);
      checkVal("ferr_next_cnt", ByteCount, 16'd1);
      waitNeg(4); nCS = 1'b1; waitNeg(8);

      // Full FIFO with a pop in the same cycle as the fifth push
      applyReset();
      nCS = 1'b0; waitNeg(4);
      for (int k = 0; k < 4; k++) sendBits(8'h20 + 8'(k), 1'b1, 8, 0);
      sendBits(8'h24, 1'b1, 8, 2);
      checkVal("full_noovf", 16'(Overflow), 16'd0);
      checkVal("full_cnt", ByteCount, 16'd5);
      waitNeg(4); nCS = 1'b1; waitNeg(8);
      drain();
      expQ = '{9'h120, 9'h121, 9'h122, 9'h123, 9'h124};
      checkQueue("full_order", expQ);

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
